sample_sequencer: RTL and testbench



---
 rtl/sample_sequencer_if.sv | 30 +++
 rtl/sample_sequencer.sv | 111 +++++++++++
 tb/tb_sample_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sample_sequencer_if.sv
// Triangle/box hand-off from the bounding-box stage and sample stream to sampletest.
// The master drives the R14 side; the slave (sequencer) drives the R15 side and halt.
interface sample_sequencer_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U  [COLORS];
  logic signed [SIGFIG-1:0] box_R14S    [2][2];
  logic                     validTri_R14H;
  logic        [3:0]        subSample_RnnnnU;

  logic                     halt_RnnnnH;
  logic signed [SIGFIG-1:0] tri_R15S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R15U  [COLORS];
  logic signed [SIGFIG-1:0] sample_R15S [2];
  logic                     validSamp_R15H;

  modport master (
    output tri_R14S, color_R14U, box_R14S, validTri_R14H, subSample_RnnnnU,
    input  halt_RnnnnH, tri_R15S, color_R15U, sample_R15S, validSamp_R15H
  );

  modport slave (
    input  tri_R14S, color_R14U, box_R14S, validTri_R14H, subSample_RnnnnU,
    output halt_RnnnnH, tri_R15S, color_R15U, sample_R15S, validSamp_R15H
  );
endinterface

// File: rtl/sample_sequencer.sv
// Walks every sample of a triangle's bounding box in row-major order, one per clock,
// at the MSAA sample spacing; stalls upstream while a box is being walked.
module sample_sequencer #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic              clk,
  input  logic              rst,
  sample_sequencer_if.slave bus
);
  typedef enum logic {WAIT_STATE = 1'b0, TEST_STATE = 1'b1} state_t;

  localparam logic signed [SIGFIG-1:0] STEP_1SPP  = SIGFIG'(1 << RADIX);
  localparam logic signed [SIGFIG-1:0] STEP_4SPP  = SIGFIG'(1 << (RADIX - 1));
  localparam logic signed [SIGFIG-1:0] STEP_16SPP = SIGFIG'(1 << (RADIX - 2));
  localparam logic signed [SIGFIG-1:0] STEP_64SPP = SIGFIG'(1 << (RADIX - 3));

  state_t                   state;
  logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
  logic signed [SIGFIG-1:0] step;
  logic signed [SIGFIG-1:0] samp_x, samp_y;
  logic                     box_inv;

  logic signed [SIGFIG-1:0] step_sel;
  logic signed [SIGFIG-1:0] x_next, y_next;
  logic                     x_end, y_end;

  always_comb begin
    case (bus.subSample_RnnnnU)
      4'b1000: step_sel = STEP_1SPP;
      4'b0100: step_sel = STEP_4SPP;
      4'b0010: step_sel = STEP_16SPP;
      4'b0001: step_sel = STEP_64SPP;
      default: step_sel = STEP_1SPP;
    endcase
  end

  always_comb begin
    x_next = samp_x + step;
    y_next = samp_y + step;
    x_end  = (x_next > ur_x);
    y_end  = (y_next > ur_y);
  end

  assign bus.halt_RnnnnH    = (state == TEST_STATE);
  assign bus.sample_R15S[0] = samp_x;
  assign bus.sample_R15S[1] = samp_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WAIT_STATE;
      bus.validSamp_R15H <= 1'b0;
      samp_x             <= '0;
      samp_y             <= '0;
      ll_x               <= '0;
      ll_y               <= '0;
      ur_x               <= '0;
      ur_y               <= '0;
      step               <= '0;
      box_inv            <= 1'b0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          bus.tri_R15S[v][a] <= '0;
      for (int c = 0; c < COLORS; c++)
        bus.color_R15U[c] <= '0;
    end else begin
      case (state)
        WAIT_STATE: begin
          if (bus.validTri_R14H) begin
            for (int v = 0; v < VERTS; v++)
              for (int a = 0; a < AXIS; a++)
                bus.tri_R15S[v][a] <= bus.tri_R14S[v][a];
            for (int c = 0; c < COLORS; c++)
              bus.color_R15U[c] <= bus.color_R14U[c];
            ll_x               <= bus.box_R14S[0][0];
            ll_y               <= bus.box_R14S[0][1];
            ur_x               <= bus.box_R14S[1][0];
            ur_y               <= bus.box_R14S[1][1];
            // An inverted box on either axis yields only its LL sample.
            box_inv            <= (bus.box_R14S[1][0] < bus.box_R14S[0][0]) ||
                                  (bus.box_R14S[1][1] < bus.box_R14S[0][1]);
            step               <= step_sel;
            samp_x             <= bus.box_R14S[0][0];
            samp_y             <= bus.box_R14S[0][1];
            bus.validSamp_R15H <= 1'b1;
            state              <= TEST_STATE;
          end else begin
            bus.validSamp_R15H <= 1'b0;
          end
        end
        TEST_STATE: begin
          if (!x_end && !box_inv) begin
            samp_x             <= x_next;
            bus.validSamp_R15H <= 1'b1;
          end else if (!y_end && !box_inv) begin
            samp_x             <= ll_x;
            samp_y             <= y_next;
            bus.validSamp_R15H <= 1'b1;
          end else begin
            bus.validSamp_R15H <= 1'b0;
            state              <= WAIT_STATE;
          end
        end
        default: state <= WAIT_STATE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_sequencer.sv
// Directed and randomized bench for sample_sequencer; expected sample streams come from
// nested loops over the box, compared cycle by cycle with immediate assertions.
module tb_sample_sequencer;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  int   exp_x[$];
  int   exp_y[$];
  logic signed [SIGFIG-1:0] cur_tri [VERTS][AXIS];
  logic        [SIGFIG-1:0] cur_col [COLORS];

  sample_sequencer_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

  sample_sequencer #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] ss);
    case (ss)
      4'b1000: return 1024;
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  task automatic build_exp(input int llx, input int lly, input int urx, input int ury,
                           input int step);
    exp_x.delete();
    exp_y.delete();
    if (urx < llx || ury < lly) begin
      exp_x.push_back(llx);
      exp_y.push_back(lly);
    end else begin
      for (int y = lly; y <= ury; y += step)
        for (int x = llx; x <= urx; x += step) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
        end
    end
  endtask

  task automatic check_payload(input string tag);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        chk({tag, "_tri"}, int'(bus.tri_R15S[v][a]), int'(cur_tri[v][a]));
    for (int c = 0; c < COLORS; c++)
      chk({tag, "_color"}, int'(bus.color_R15U[c]), int'(cur_col[c]));
  endtask

  // Presents a triangle at the current negedge (DUT idle), then checks the whole walk
  // and the bubble cycle after it. With hold_valid the caller must start the next walk.
  task automatic walk(input string tag, input int llx, input int lly, input int urx,
                      input int ury, input logic [3:0] ss, input bit hold_valid,
                      input logic [3:0] ss_mid);
    build_exp(llx, lly, urx, ury, step_of(ss));
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) begin
        cur_tri[v][a]     = SIGFIG'($urandom);
        bus.tri_R14S[v][a] = cur_tri[v][a];
      end
    for (int c = 0; c < COLORS; c++) begin
      cur_col[c]        = SIGFIG'($urandom);
      bus.color_R14U[c] = cur_col[c];
    end
    bus.box_R14S[0][0]   = SIGFIG'(llx);
    bus.box_R14S[0][1]   = SIGFIG'(lly);
    bus.box_R14S[1][0]   = SIGFIG'(urx);
    bus.box_R14S[1][1]   = SIGFIG'(ury);
    bus.subSample_RnnnnU = ss;
    bus.validTri_R14H    = 1'b1;
    @(negedge clk);
    bus.subSample_RnnnnU = ss_mid;
    if (!hold_valid) bus.validTri_R14H = 1'b0;
    for (int i = 0; i < exp_x.size(); i++) begin
      chk({tag, "_valid"}, int'(bus.validSamp_R15H), 1);
      chk({tag, "_halt"}, int'(bus.halt_RnnnnH), 1);
      chk({tag, "_x"}, int'(bus.sample_R15S[0]), exp_x[i]);
      chk({tag, "_y"}, int'(bus.sample_R15S[1]), exp_y[i]);
      check_payload(tag);
      @(negedge clk);
    end
    chk({tag, "_bubble_valid"}, int'(bus.validSamp_R15H), 0);
    chk({tag, "_bubble_halt"}, int'(bus.halt_RnnnnH), 0);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.validTri_R14H    = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) begin
        bus.tri_R14S[v][a] = '0;
        cur_tri[v][a]      = '0;
      end
    for (int c = 0; c < COLORS; c++) begin
      bus.color_R14U[c] = '0;
      cur_col[c]        = '0;
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        bus.box_R14S[i][j] = '0;

    repeat (3) @(negedge clk);
    chk("rst_valid", int'(bus.validSamp_R15H), 0);
    chk("rst_halt", int'(bus.halt_RnnnnH), 0);
    chk("rst_x", int'(bus.sample_R15S[0]), 0);
    chk("rst_y", int'(bus.sample_R15S[1]), 0);
    check_payload("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", int'(bus.validSamp_R15H), 0);

    walk("spp1", 0, 0, 1024, 1024, 4'b1000, 1'b0, 4'b1000);
    walk("spp4", 0, 0, 1024, 1024, 4'b0100, 1'b0, 4'b0100);
    walk("degen", 2048, 3072, 2048, 3072, 4'b1000, 1'b0, 4'b1000);
    walk("inv_x", 1024, 0, 0, 2048, 4'b0100, 1'b0, 4'b0100);
    walk("inv_y", 0, 1024, 2048, 0, 4'b1000, 1'b0, 4'b1000);
    walk("b2b_a", 0, 0, 512, 512, 4'b0010, 1'b1, 4'b0010);
    walk("b2b_b", -1024, -512, 0, 0, 4'b0100, 1'b0, 4'b0100);
    walk("mid_a", 0, 0, 2048, 1024, 4'b1000, 1'b0, 4'b0001);
    walk("mid_b", 0, 0, 256, 128, 4'b0001, 1'b0, 4'b0001);
    walk("nohot", 0, 0, 1024, 0, 4'b0110, 1'b0, 4'b0000);
    walk("zero", 512, 512, 2560, 512, 4'b0000, 1'b0, 4'b0000);

    // Reset on the third sample of a 16-sample walk.
    build_exp(0, 0, 768, 768, 256);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) begin
        cur_tri[v][a]      = SIGFIG'($urandom);
        bus.tri_R14S[v][a] = cur_tri[v][a];
      end
    for (int c = 0; c < COLORS; c++) begin
      cur_col[c]        = SIGFIG'($urandom);
      bus.color_R14U[c] = cur_col[c];
    end
    bus.box_R14S[0][0]   = '0;
    bus.box_R14S[0][1]   = '0;
    bus.box_R14S[1][0]   = SIGFIG'(768);
    bus.box_R14S[1][1]   = SIGFIG'(768);
    bus.subSample_RnnnnU = 4'b0010;
    bus.validTri_R14H    = 1'b1;
    @(negedge clk);
    bus.validTri_R14H = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rw_valid", int'(bus.validSamp_R15H), 1);
      chk("rw_x", int'(bus.sample_R15S[0]), exp_x[i]);
      chk("rw_y", int'(bus.sample_R15S[1]), exp_y[i]);
      if (i < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        cur_tri[v][a] = '0;
    for (int c = 0; c < COLORS; c++)
      cur_col[c] = '0;
    chk("rw_rst_valid", int'(bus.validSamp_R15H), 0);
    chk("rw_rst_halt", int'(bus.halt_RnnnnH), 0);
    chk("rw_rst_x", int'(bus.sample_R15S[0]), 0);
    chk("rw_rst_y", int'(bus.sample_R15S[1]), 0);
    check_payload("rw_rst");
    @(negedge clk);
    chk("rw_idle_valid", int'(bus.validSamp_R15H), 0);
    walk("after_rst", 1536, -2048, 2560, -1024, 4'b0100, 1'b0, 4'b1000);

    for (int t = 0; t < 30; t++) begin
      logic [3:0] ss, ss_mid;
      int step, llx, lly, urx, ury;
      case ($urandom_range(0, 4))
        0: ss = 4'b1000;
        1: ss = 4'b0100;
        2: ss = 4'b0010;
        3: ss = 4'b0001;
        default: ss = 4'($urandom);
      endcase
      ss_mid = 4'($urandom);
      step = step_of(ss);
      llx  = (int'($urandom_range(0, 16)) - 8) * step;
      lly  = (int'($urandom_range(0, 16)) - 8) * step;
      urx  = llx + int'($urandom_range(0, 3)) * step;
      ury  = lly + int'($urandom_range(0, 3)) * step;
      if ($urandom_range(0, 3) == 0) urx = urx + int'($urandom_range(0, step - 1));
      if ($urandom_range(0, 7) == 0) urx = llx - step;
      if ($urandom_range(0, 7) == 0) ury = lly - 1;
      walk("rand", llx, lly, urx, ury, ss, 1'b0, ss_mid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
